// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the AVR/SNES SRAM bridge.
package sram_bridge_pkg;

    // Encodings are visible on debug[2:0] and must stay fixed.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_STROBE = 3'd1,
        RD_LATCH  = 3'd2,
        WR_SETUP  = 3'd3,
        WR_PULSE  = 3'd4,
        WR_HOLD   = 3'd5
    } state_e;

    localparam int DBG_MODE_BIT = 7;
    localparam int DBG_BUSY_BIT = 6;
    localparam int DBG_STATE_W  = 3;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/addr_sreg.sv
// AVR address register: serial shift-in, single-step increment with wrap.
module addr_sreg #(
    parameter int AW = 21
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          en_i,
    input  logic          si_i,
    input  logic          inc_i,
    input  logic          ld_en_i,
    output logic [AW-1:0] addr_o
);

    logic [AW-1:0] addr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q <= '0;
        end else if (ld_en_i) begin
            if (en_i) begin
                addr_q <= {addr_q[AW-2:0], si_i};
            end else if (inc_i) begin
                addr_q <= addr_q + AW'(1);
            end
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/sram_bridge.sv
// SRAM bridge: AVR strobe engine with wait states plus SNES pass-through,
// switching ownership only between accesses.
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int AW          = 21,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int AUTO_INC    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          snes_mode,
    input  logic          sreg_en_n,
    input  logic          si,
    input  logic          counter_n,
    input  logic          avr_we_n,
    input  logic          avr_oe_n,
    input  logic [DW-1:0] avr_wdata,
    output logic [DW-1:0] avr_rdata,
    input  logic [AW-1:0] snes_addr,
    input  logic          snes_oe_n,
    output logic [DW-1:0] snes_data,
    output logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_din,
    output logic [DW-1:0] sram_dout,
    output logic          sram_dout_en,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          mode_ack,
    output logic          busy,
    output logic          done,
    output logic [7:0]    debug
);

    state_e state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic we_prev_q, oe_prev_q, cnt_prev_q;
    logic mode_ack_q;
    logic [DW-1:0] rdata_q, wdata_q;
    logic [AW-1:0] addr;

    logic ce_n_q, oe_n_q, we_n_q, dout_en_q, done_q;
    logic ce_n_d, oe_n_d, we_n_d, dout_en_d, done_d;

    logic avr_idle, we_edge, oe_edge, cnt_edge, inc_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            we_prev_q  <= 1'b1;
            oe_prev_q  <= 1'b1;
            cnt_prev_q <= 1'b1;
        end else begin
            we_prev_q  <= avr_we_n;
            oe_prev_q  <= avr_oe_n;
            cnt_prev_q <= counter_n;
        end
    end

    assign avr_idle = (state_q == IDLE) && !mode_ack_q;
    assign we_edge  = avr_idle && we_prev_q && !avr_we_n;
    assign oe_edge  = avr_idle && oe_prev_q && !avr_oe_n;
    assign cnt_edge = cnt_prev_q && !counter_n;
    // done_q is high in the first IDLE cycle after an access, so the
    // auto-increment lands after the strobes have been released.
    assign inc_req  = cnt_edge || ((AUTO_INC != 0) && done_q);

    addr_sreg #(.AW(AW)) u_addr_sreg (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (!sreg_en_n),
        .si_i    (si),
        .inc_i   (inc_req),
        .ld_en_i (avr_idle),
        .addr_o  (addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (we_edge) begin
                    state_d = WR_SETUP;
                end else if (oe_edge) begin
                    state_d = RD_STROBE;
                    wait_d  = WAIT_W'(WAIT_CYCLES);
                end
            end
            RD_STROBE: begin
                if (wait_q == '0) state_d = RD_LATCH;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            RD_LATCH: state_d = IDLE;
            WR_SETUP: begin
                state_d = WR_PULSE;
                wait_d  = WAIT_W'(WAIT_CYCLES);
            end
            WR_PULSE: begin
                if (wait_q == '0) state_d = WR_HOLD;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            WR_HOLD:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        dout_en_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            RD_STROBE: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            RD_LATCH: done_d = 1'b1;
            WR_SETUP: begin
                ce_n_d    = 1'b0;
                dout_en_d = 1'b1;
            end
            WR_PULSE: begin
                ce_n_d    = 1'b0;
                we_n_d    = 1'b0;
                dout_en_d = 1'b1;
            end
            WR_HOLD: begin
                ce_n_d    = 1'b0;
                dout_en_d = 1'b1;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            dout_en_q  <= 1'b0;
            done_q     <= 1'b0;
            mode_ack_q <= 1'b0;
            rdata_q    <= '0;
            wdata_q    <= '0;
        end else begin
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            dout_en_q <= dout_en_d;
            done_q    <= done_d;
            if (state_q == IDLE)     mode_ack_q <= snes_mode;
            if (state_q == RD_LATCH) rdata_q    <= sram_din;
            if (we_edge)             wdata_q    <= avr_wdata;
        end
    end

    assign sram_addr    = mode_ack_q ? snes_addr : addr;
    assign sram_oe_n    = mode_ack_q ? snes_oe_n : oe_n_q;
    assign sram_ce_n    = mode_ack_q ? snes_oe_n : ce_n_q;
    assign sram_we_n    = mode_ack_q ? 1'b1      : we_n_q;
    assign sram_dout_en = mode_ack_q ? 1'b0      : dout_en_q;
    assign snes_data    = mode_ack_q ? sram_din  : '0;
    assign sram_dout    = wdata_q;
    assign avr_rdata    = rdata_q;
    assign mode_ack     = mode_ack_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

    always_comb begin
        debug                        = '0;
        debug[DBG_MODE_BIT]          = mode_ack_q;
        debug[DBG_BUSY_BIT]          = busy;
        debug[DBG_STATE_W-1:0]       = state_q;
    end

endmodule

// File: tb/tb_sram_bridge.sv
// Scoreboard bench for sram_bridge with a small byte-wide SRAM model.
module tb_sram_bridge;

    localparam int AW = 21;
    localparam int DW = 8;
    localparam logic [AW-1:0] AMASK = '1;

    logic clk = 1'b0;
    logic reset, snes_mode, sreg_en_n, si, counter_n, avr_we_n, avr_oe_n, snes_oe_n;
    logic [DW-1:0] avr_wdata, avr_rdata, snes_data, sram_din, sram_dout;
    logic [AW-1:0] snes_addr, sram_addr;
    logic sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n, mode_ack, busy, done;
    logic [7:0] debug;

    always #5 clk = ~clk;

    sram_bridge #(.AW(AW), .DW(DW), .WAIT_CYCLES(1), .AUTO_INC(1)) dut (
        .clk(clk), .reset(reset), .snes_mode(snes_mode), .sreg_en_n(sreg_en_n),
        .si(si), .counter_n(counter_n), .avr_we_n(avr_we_n), .avr_oe_n(avr_oe_n),
        .avr_wdata(avr_wdata), .avr_rdata(avr_rdata), .snes_addr(snes_addr),
        .snes_oe_n(snes_oe_n), .snes_data(snes_data), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .mode_ack(mode_ack), .busy(busy), .done(done), .debug(debug)
    );

    // SRAM model: 256 bytes aliased on the low address byte.
    logic [7:0] mem [0:255];
    logic       pre_we = 1'b0;
    logic [7:0] pre_a, pre_d;
    assign sram_din = mem[sram_addr[7:0]];
    always @(negedge clk) begin
        if (pre_we) mem[pre_a] = pre_d;
        if (!sram_we_n && !sram_ce_n && sram_dout_en) mem[sram_addr[7:0]] = sram_dout;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        bit            is_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];
    logic [AW-1:0] exp_addr;

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("sb_pending", exp_q.size(), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_addr", sram_addr, e.addr);
                if (e.is_rd) check("sb_rdata", avr_rdata, e.data);
                else         check("sb_wmem", mem[e.addr[7:0]], e.data);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(negedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic load_addr(input logic [AW-1:0] v);
        sreg_en_n = 1'b0;
        for (int i = AW - 1; i >= 0; i--) begin
            si = v[i];
            tick;
        end
        sreg_en_n = 1'b1;
        exp_addr  = v;
    endtask

    task automatic run_access(input bit wr, input bit rd, input logic [7:0] wd,
                              input bit mode_mid, output int lat, output int we_lo,
                              output int oe_lo, output int den_hi);
        lat = 0; we_lo = 0; oe_lo = 0; den_hi = 0;
        avr_wdata = wd;
        if (wr) avr_we_n = 1'b0;
        if (rd) avr_oe_n = 1'b0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            tick;
            if (mode_mid && n == 2) snes_mode = 1'b1;
            if (!sram_we_n)  we_lo++;
            if (!sram_oe_n)  oe_lo++;
            if (sram_dout_en) den_hi++;
            if (done) lat = n;
        end
        if (lat == 0) check("access_timeout", lat, 1);
        avr_we_n = 1'b1;
        avr_oe_n = 1'b1;
    endtask

    task automatic push(input bit is_rd, input logic [7:0] d);
        exp_t e;
        e.is_rd = is_rd;
        e.addr  = exp_addr;
        e.data  = d;
        exp_q.push_back(e);
        exp_addr = (exp_addr + 1'b1) & AMASK;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, we_lo, oe_lo, den_hi;
        bit busy_seen, done_seen;
        reset = 1'b1; snes_mode = 1'b0; sreg_en_n = 1'b1; si = 1'b0; counter_n = 1'b1;
        avr_we_n = 1'b1; avr_oe_n = 1'b1; avr_wdata = '0; snes_addr = 21'h012345;
        snes_oe_n = 1'b1;
        tick; tick;
        reset = 1'b0;
        check("rst_addr", sram_addr, 0);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("rst_dout_en", sram_dout_en, 0);
        check("rst_done", done, 0);
        check("rst_rdata", avr_rdata, 0);
        check("rst_debug", debug, 0);

        // Serial load then one counter pulse
        load_addr(21'h0ABCDE);
        check("sreg_load", sram_addr, 21'h0ABCDE);
        counter_n = 1'b0; tick; counter_n = 1'b1; tick;
        exp_addr = 21'h0ABCDF;
        check("counter_inc", sram_addr, exp_addr);

        // Write 0x5A
        push(1'b0, 8'h5A);
        run_access(1'b1, 1'b0, 8'h5A, 1'b0, lat, we_lo, oe_lo, den_hi);
        check("wr_latency", lat, 5);
        check("wr_we_low", we_lo, 2);
        check("wr_den_high", den_hi, 4);
        tick;
        check("wr_autoinc", sram_addr, 21'h0ABCE0);

        // Read 0xC3
        preload(8'hE0, 8'hC3);
        push(1'b1, 8'hC3);
        run_access(1'b0, 1'b1, 8'h00, 1'b0, lat, we_lo, oe_lo, den_hi);
        check("rd_latency", lat, 4);
        check("rd_oe_low", oe_lo, 2);
        check("rd_we_low", we_lo, 0);
        check("rd_data", avr_rdata, 8'hC3);
        tick;
        check("rd_autoinc", sram_addr, 21'h0ABCE1);

        // Read back the earlier write
        load_addr(21'h0ABCDF);
        push(1'b1, 8'h5A);
        run_access(1'b0, 1'b1, 8'h00, 1'b0, lat, we_lo, oe_lo, den_hi);
        check("rb_data", avr_rdata, 8'h5A);
        tick;

        // Wrap at all-ones
        preload(8'hFF, 8'h77);
        load_addr(21'h1FFFFF);
        push(1'b1, 8'h77);
        run_access(1'b0, 1'b1, 8'h00, 1'b0, lat, we_lo, oe_lo, den_hi);
        tick;
        check("wrap_addr", sram_addr, 21'h000000);

        // Mode switch requested during WR_PULSE
        preload(8'h45, 8'h3C);
        push(1'b0, 8'h66);
        run_access(1'b1, 1'b0, 8'h66, 1'b1, lat, we_lo, oe_lo, den_hi);
        check("msw_latency", lat, 5);
        check("msw_we_low", we_lo, 2);
        check("msw_ack_held", mode_ack, 0);
        tick;
        check("msw_ack", mode_ack, 1);
        check("msw_snes_addr", sram_addr, 21'h012345);
        snes_oe_n = 1'b0;
        #1;
        check("snes_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, 4'b0010);
        check("snes_data", snes_data, 8'h3C);
        avr_oe_n = 1'b0;
        busy_seen = 1'b0;
        repeat (6) begin
            tick;
            if (busy) busy_seen = 1'b1;
        end
        check("snes_no_avr", busy_seen, 0);
        avr_oe_n = 1'b1; snes_oe_n = 1'b1; snes_mode = 1'b0;
        tick; tick;
        check("back_to_avr", mode_ack, 0);
        check("back_addr", sram_addr, exp_addr);

        // Reset during RD_STROBE
        avr_oe_n = 1'b0;
        tick;
        check("rs_debug", debug, 8'h41);
        reset = 1'b1; avr_oe_n = 1'b1;
        tick;
        reset = 1'b0;
        check("rs_state", debug, 0);
        check("rs_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}, 4'b1110);
        check("rs_addr", sram_addr, 0);
        check("rs_rdata", avr_rdata, 0);
        done_seen = done;
        repeat (5) begin
            tick;
            if (done) done_seen = 1'b1;
        end
        check("rs_no_done", done_seen, 0);
        exp_addr = '0;

        // Simultaneous we/oe edge: write wins
        push(1'b0, 8'hA5);
        run_access(1'b1, 1'b1, 8'hA5, 1'b0, lat, we_lo, oe_lo, den_hi);
        check("both_latency", lat, 5);
        check("both_oe_low", oe_lo, 0);
        check("both_we_low", we_lo, 2);
        check("both_rdata", avr_rdata, 0);
        tick; tick;
        check("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
